// File: rtl/dcm_phase_ctl353.sv
// Phase-shift sequencer for the SDRAM clock DCM: turns CPU phase commands into
// single PSEN steps with a PSDONE handshake and tracks the signed current phase.
module dcm_phase_ctl353 #(
    parameter int PHASE_BITS  = 9,
    parameter int PHASE_LIMIT = 160,
    parameter int RST_CYCLES  = 4,
    parameter int TIMEOUT     = 1023
) (
    input  logic                         sclk,
    input  logic                         nrst,
    input  logic                         cmd_we,
    input  logic [1:0]                   cmd_op,
    input  logic signed [PHASE_BITS-1:0] cmd_phase,
    input  logic                         dcm_done,
    input  logic                         locked,
    output logic                         dcm_rst,
    output logic                         dcm_en,
    output logic                         dcm_incdec,
    output logic signed [PHASE_BITS-1:0] phase,
    output logic                         busy,
    output logic                         err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic signed [PHASE_BITS:0]   LIM_HI = (PHASE_BITS + 1)'(PHASE_LIMIT);
    localparam logic signed [PHASE_BITS:0]   LIM_LO = -LIM_HI;
    localparam logic signed [PHASE_BITS:0]   ONE_W  = 1;
    localparam logic signed [PHASE_BITS-1:0] ONE    = 1;

    localparam logic [1:0] OP_SET  = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_RST  = 2'b11;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_WAIT_LOCK,
        ST_IDLE,
        ST_STEP,
        ST_WAIT_DONE
    } state_t;

    state_t                       state_reg, state_next;
    logic [CNT_W-1:0]             cnt_reg, cnt_next;
    logic signed [PHASE_BITS-1:0] phase_reg, phase_next;
    logic signed [PHASE_BITS-1:0] target_reg, target_next;
    logic signed [PHASE_BITS-1:0] phase_stepped;
    logic signed [PHASE_BITS:0]   target_wide, cmd_wide;
    logic                         err_reg, err_next;
    logic                         dir_reg, dir_next;
    logic                         cmd_accept;

    function automatic logic signed [PHASE_BITS-1:0] clamp(input logic signed [PHASE_BITS:0] v);
        if (v > LIM_HI)
            return LIM_HI[PHASE_BITS-1:0];
        else if (v < LIM_LO)
            return LIM_LO[PHASE_BITS-1:0];
        else
            return v[PHASE_BITS-1:0];
    endfunction

    assign target_wide   = {target_reg[PHASE_BITS-1], target_reg};
    assign cmd_wide      = {cmd_phase[PHASE_BITS-1], cmd_phase};
    assign phase_stepped = dir_reg ? (phase_reg + ONE) : (phase_reg - ONE);
    assign cmd_accept    = cmd_we && (state_reg != ST_RESET) && (state_reg != ST_WAIT_LOCK);

    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            state_reg  <= ST_RESET;
            cnt_reg    <= '0;
            phase_reg  <= '0;
            target_reg <= '0;
            err_reg    <= 1'b0;
            dir_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            phase_reg  <= phase_next;
            target_reg <= target_next;
            err_reg    <= err_next;
            dir_reg    <= dir_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        phase_next  = phase_reg;
        target_next = target_reg;
        err_next    = err_reg;
        dir_next    = dir_reg;

        if (cmd_we)
            err_next = 1'b0;

        if (cmd_accept) begin
            case (cmd_op)
                OP_SET:  target_next = clamp(cmd_wide);
                OP_INC:  target_next = clamp(target_wide + ONE_W);
                OP_DEC:  target_next = clamp(target_wide - ONE_W);
                default: ;
            endcase
        end

        case (state_reg)
            ST_RESET: begin
                phase_next  = '0;
                target_next = '0;
                if (cnt_reg == CNT_W'(RST_CYCLES - 1)) begin
                    state_next = ST_WAIT_LOCK;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (locked) begin
                    state_next = ST_IDLE;
                end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_IDLE: begin
                // A same-cycle retarget back onto the current phase must not launch a step
                if ((target_reg != phase_reg) && (target_next != phase_reg))
                    state_next = ST_STEP;
            end
            ST_STEP: begin
                dir_next   = (target_reg > phase_reg);
                cnt_next   = '0;
                state_next = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // dcm_done is still high for the first two cycles after dcm_en
                if ((cnt_reg >= CNT_W'(2)) && dcm_done) begin
                    phase_next = phase_stepped;
                    state_next = (phase_stepped != target_next) ? ST_STEP : ST_IDLE;
                end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                    err_next    = 1'b1;
                    target_next = phase_reg;
                    state_next  = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = ST_RESET;
        endcase

        if (cmd_we && (cmd_op == OP_RST)) begin
            state_next  = ST_RESET;
            cnt_next    = '0;
            phase_next  = '0;
            target_next = '0;
        end
    end

    always_comb begin
        dcm_rst    = (state_reg == ST_RESET);
        dcm_en     = (state_reg == ST_STEP);
        dcm_incdec = (state_reg == ST_STEP) && (target_reg > phase_reg);
        busy       = (state_reg != ST_IDLE);
    end

    assign phase = phase_reg;
    assign err   = err_reg;

endmodule

// File: tb/tb_dcm_phase_ctl353.sv
// Directed bench for dcm_phase_ctl353 with a behavioural DCM phase-shift/lock model.
module tb_dcm_phase_ctl353;

    logic              sclk = 1'b0;
    logic              nrst = 1'b0;
    logic              cmd_we = 1'b0;
    logic [1:0]        cmd_op = 2'b00;
    logic signed [8:0] cmd_phase = '0;
    logic              dcm_done;
    logic              locked;
    logic              dcm_rst, dcm_en, dcm_incdec, busy, err;
    logic signed [8:0] phase;

    int nvec = 0;
    int nfail = 0;
    int en_total = 0;
    int inc_total = 0;
    int viol = 0;
    logic en_prev = 1'b0;

    int   done_delay = 10;
    logic never_done = 1'b0;
    int   dcnt;
    int   lcnt;
    localparam int LOCK_DELAY = 20;

    always #5 sclk = ~sclk;

    dcm_phase_ctl353 dut (
        .sclk       (sclk),
        .nrst       (nrst),
        .cmd_we     (cmd_we),
        .cmd_op     (cmd_op),
        .cmd_phase  (cmd_phase),
        .dcm_done   (dcm_done),
        .locked     (locked),
        .dcm_rst    (dcm_rst),
        .dcm_en     (dcm_en),
        .dcm_incdec (dcm_incdec),
        .phase      (phase),
        .busy       (busy),
        .err        (err)
    );

    // DCM model: done drops the cycle after PSEN and returns done_delay cycles later
    always @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            dcm_done <= 1'b1;
            dcnt     <= 0;
            locked   <= 1'b0;
            lcnt     <= 0;
        end else if (dcm_rst) begin
            dcm_done <= 1'b1;
            dcnt     <= 0;
            locked   <= 1'b0;
            lcnt     <= 0;
        end else begin
            if (!locked) begin
                if (lcnt == LOCK_DELAY - 1) locked <= 1'b1;
                else lcnt <= lcnt + 1;
            end
            if (dcm_en) begin
                dcm_done <= 1'b0;
                dcnt     <= done_delay;
            end else if (dcnt != 0) begin
                dcnt <= dcnt - 1;
                if (dcnt == 1 && !never_done) dcm_done <= 1'b1;
            end
        end
    end

    always @(negedge sclk) begin
        if (dcm_en) begin
            en_total++;
            if (dcm_incdec) inc_total++;
            if (en_prev || dcm_rst) viol++;
        end
        en_prev = dcm_en;
    end

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Called at a negedge; the command is sampled on the following posedge
    task automatic issue(input logic [1:0] op, input int ph);
        cmd_we    = 1'b1;
        cmd_op    = op;
        cmd_phase = 9'(ph);
        @(negedge sclk);
        cmd_we    = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int t = 0;
        while (busy && t < limit) begin
            @(negedge sclk);
            t++;
        end
        check(name, int'(busy), 0);
    endtask

    typedef struct {
        logic [1:0] op;
        int         ph;
        int         exp_phase;
        int         exp_en;
        int         exp_inc;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int en0, inc0, k;

        vecs[0] = '{2'd0,    5,    5,   5,   5};
        vecs[1] = '{2'd1,    0,    6,   1,   1};
        vecs[2] = '{2'd2,    0,    5,   1,   0};
        vecs[3] = '{2'd0,   -3,   -3,   8,   0};
        vecs[4] = '{2'd0,  255,  160, 163, 163};
        vecs[5] = '{2'd1,    0,  160,   0,   0};
        vecs[6] = '{2'd0, -200, -160, 320,   0};
        vecs[7] = '{2'd2,    0, -160,   0,   0};
        vecs[8] = '{2'd0,    0,    0, 160, 160};

        // Reset state and DCM reset pulse width
        repeat (3) @(negedge sclk);
        check("rst_dcm_rst", int'(dcm_rst), 1);
        check("rst_busy", int'(busy), 1);
        check("rst_phase", int'(phase), 0);
        check("rst_err", int'(err), 0);
        check("rst_en", int'(dcm_en), 0);
        nrst = 1'b1;
        k = 0;
        while (dcm_rst && k < 50) begin
            k++;
            @(negedge sclk);
        end
        check("rst_width", k, 4);
        wait_idle("lock_idle", 200);
        check("lock_locked", int'(locked), 1);
        check("lock_phase", int'(phase), 0);
        check("lock_err", int'(err), 0);

        // Table of moves, each run to completion
        for (int i = 0; i < 9; i++) begin
            en0  = en_total;
            inc0 = inc_total;
            issue(vecs[i].op, vecs[i].ph);
            @(negedge sclk);
            wait_idle($sformatf("v%0d_idle", i), 6000);
            check($sformatf("v%0d_phase", i), int'(phase), vecs[i].exp_phase);
            check($sformatf("v%0d_en", i), en_total - en0, vecs[i].exp_en);
            check($sformatf("v%0d_inc", i), inc_total - inc0, vecs[i].exp_inc);
            check($sformatf("v%0d_err", i), int'(err), 0);
        end

        // Done timeout: first step never completes
        never_done = 1'b1;
        issue(2'd0, 3);
        @(negedge sclk);
        check("to_latency_en", int'(dcm_en), 1);
        check("to_incdec", int'(dcm_incdec), 1);
        k = 0;
        while (!err && k < 1200) begin
            @(negedge sclk);
            k++;
        end
        check("to_cycles", k, 1024);
        check("to_phase", int'(phase), 0);
        check("to_busy", int'(busy), 0);
        @(negedge sclk);
        check("to_stay_idle", int'(busy), 0);
        issue(2'd0, 0);
        check("to_err_clear", int'(err), 0);
        never_done = 1'b0;

        // DCM reset in the middle of a step
        issue(2'd0, 10);
        k = 0;
        while (!dcm_en && k < 10) begin
            @(negedge sclk);
            k++;
        end
        check("abort_first_en", int'(dcm_en), 1);
        repeat (3) @(negedge sclk);
        en0 = en_total;
        issue(2'd3, 0);
        check("abort_dcm_rst", int'(dcm_rst), 1);
        check("abort_phase", int'(phase), 0);
        check("abort_busy", int'(busy), 1);
        wait_idle("abort_idle", 300);
        check("abort_no_en", en_total - en0, 0);
        check("abort_final_phase", int'(phase), 0);

        // Retarget while moving: overshoot by the in-flight step, then back off
        en0  = en_total;
        inc0 = inc_total;
        issue(2'd0, 8);
        k = 0;
        while (phase != 9'sd3 && k < 200) begin
            @(negedge sclk);
            k++;
        end
        check("retgt_reach3", int'(phase), 3);
        issue(2'd0, 2);
        wait_idle("retgt_idle", 300);
        check("retgt_phase", int'(phase), 2);
        check("retgt_en", en_total - en0, 6);
        check("retgt_inc", inc_total - inc0, 4);

        check("en_rules", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
